stack_controller: RTL and testbench

- Multicycle control unit for the 8-bit stack-machine datapath. Decodes the 3-bit opcode and the ALU Zero flag, and sequences every datapath control strobe.
- The datapath consumes the strobes and returns op and Zero.
- Instruction format: op = Instr[7:5], operand/address = Instr[4:0]. The 5-bit address space is shared by code and data.

---
 rtl/stack_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_stack_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - multicycle control unit for the 8-bit stack-machine datapath
//
// Purpose:
//   Decodes the 3-bit opcode (Instr[7:5]) and the ALU Zero flag and sequences
//   every datapath control strobe. Outputs are a Moore decode of the state
//   register; the one exception is PCWrite in JZ_T, which follows Zero.
//
// Optional feature (macro CTRL_STEP_EN):
//   Adds the step input and a WAIT state. WAIT is the reset state and is
//   re-entered after every instruction. One step pulse runs one instruction.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   step        in   (CTRL_STEP_EN only) leave WAIT and run one instruction
//   op[2:0]     in   opcode from the instruction register
//   Zero        in   ALU zero flag
//   RegWrite    out  held 0
//   LoadA/LoadB out  load A/B register from StackOut
//   PCWrite     out  PC <= Result[4:0]
//   AdrSrc      out  0: address = PC, 1: address = Result[4:0]
//   MemWrite    out  mem[addr] <= B
//   IRWrite     out  load IR and OldPC
//   Push/Pop/Tos out stack push Result / pop / drive top onto StackOut
//   ResultSrc   out  00 AluOut, 01 Data, 10 ALUResult, 11 {3'b0, Instr[4:0]}
//   ALUSrcA     out  00 PC, 01 OldPC, 10 A
//   ALUSrcB     out  00 B, 01 imm, 10 constant 1
//   ALUControl  out  ALU operation code
//   done        out  pulse in the last state of every instruction

module stack_controller (
  input  logic       clk,
  input  logic       rst,
`ifdef CTRL_STEP_EN
  input  logic       step,
`endif
  input  logic [2:0] op,
  input  logic       Zero,
  output logic       RegWrite,
  output logic       LoadA,
  output logic       LoadB,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       Push,
  output logic       Pop,
  output logic       Tos,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       done
);

  localparam logic [2:0] ALUC_ADD   = 3'b000;
  localparam logic [2:0] ALUC_SUB   = 3'b001;
  localparam logic [2:0] ALUC_AND   = 3'b010;
  localparam logic [2:0] ALUC_NOT   = 3'b011;
  localparam logic [2:0] ALUC_PASSA = 3'b100;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POPB   = 4'd2,
    S_POPA   = 4'd3,
    S_EXEC   = 4'd4,
    S_WB     = 4'd5,
    S_MEMRD  = 4'd6,
    S_PUSHM  = 4'd7,
    S_MEMWR  = 4'd8,
    S_JMP    = 4'd9,
    S_JZ_T   = 4'd10,
    S_WAIT   = 4'd11
  } state_t;

`ifdef CTRL_STEP_EN
  localparam state_t RESET_STATE = S_WAIT;
  localparam state_t AFTER_DONE  = S_WAIT;
`else
  localparam state_t RESET_STATE = S_FETCH;
  localparam state_t AFTER_DONE  = S_FETCH;
`endif

  state_t state_q, state_d;
  // run_q is cleared by reset and set on the first clock edge after release.
  // While it is low, outputs are forced to 0 and the state is held, so the
  // reset state's outputs only appear after the first rising edge with rst=1.
  logic   run_q, run_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_STATE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    if (run_q) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_POP: state_d = S_POPB;
            OP_NOT, OP_JZ:                  state_d = S_POPA;
            OP_PUSH:                        state_d = S_MEMRD;
            OP_JMP:                         state_d = S_JMP;
            default:                        state_d = S_FETCH;
          endcase
        end
        S_POPB:   state_d = (op == OP_POP) ? S_MEMWR : S_POPA;
        S_POPA:   state_d = (op == OP_JZ) ? S_JZ_T : S_EXEC;
        S_EXEC:   state_d = S_WB;
        S_MEMRD:  state_d = S_PUSHM;
        S_WB, S_PUSHM, S_MEMWR, S_JMP, S_JZ_T: state_d = AFTER_DONE;
`ifdef CTRL_STEP_EN
        S_WAIT:   state_d = step ? S_FETCH : S_WAIT;
`endif
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Output decode
  always_comb begin
    RegWrite   = 1'b0;
    LoadA      = 1'b0;
    LoadB      = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    Push       = 1'b0;
    Pop        = 1'b0;
    Tos        = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALUC_ADD;
    done       = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          IRWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_POPB: begin
          Tos   = 1'b1;
          LoadB = 1'b1;
          Pop   = 1'b1;
        end
        S_POPA: begin
          Tos   = 1'b1;
          LoadA = 1'b1;
          Pop   = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 2'b10;
          case (op)
            OP_SUB:  ALUControl = ALUC_SUB;
            OP_AND:  ALUControl = ALUC_AND;
            OP_NOT:  ALUControl = ALUC_NOT;
            default: ALUControl = ALUC_ADD;
          endcase
        end
        S_WB: begin
          Push = 1'b1;
          done = 1'b1;
        end
        S_MEMRD: begin
          AdrSrc    = 1'b1;
          ResultSrc = 2'b11;
        end
        S_PUSHM: begin
          ResultSrc = 2'b01;
          Push      = 1'b1;
          done      = 1'b1;
        end
        S_MEMWR: begin
          AdrSrc    = 1'b1;
          ResultSrc = 2'b11;
          MemWrite  = 1'b1;
          done      = 1'b1;
        end
        S_JMP: begin
          ResultSrc = 2'b11;
          PCWrite   = 1'b1;
          done      = 1'b1;
        end
        S_JZ_T: begin
          // Pass A through so the ALU Zero flag reflects the popped value.
          ALUSrcA    = 2'b10;
          ALUControl = ALUC_PASSA;
          ResultSrc  = 2'b11;
          PCWrite    = Zero;
          done       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - table-driven bench for stack_controller
module tb_stack_controller;

  logic       clk;
  logic       rst;
  logic       step;
  logic [2:0] op;
  logic       zero;
  logic       RegWrite, LoadA, LoadB, PCWrite, AdrSrc, MemWrite, IRWrite;
  logic       Push, Pop, Tos, done;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl;

  int n_tests = 0;
  int n_fail  = 0;

  stack_controller dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CTRL_STEP_EN
    .step       (step),
`endif
    .op         (op),
    .Zero       (zero),
    .RegWrite   (RegWrite),
    .LoadA      (LoadA),
    .LoadB      (LoadB),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .Push       (Push),
    .Pop        (Pop),
    .Tos        (Tos),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {RegWrite, LoadA, LoadB, PCWrite, AdrSrc, MemWrite, IRWrite,
                Push, Pop, Tos, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, done};

  function automatic logic [19:0] pk(input bit la, lb, pcw, adr, mw, irw, psh, pp, tos,
                                     input logic [1:0] rs, asa, asb,
                                     input logic [2:0] alu, input bit dn);
    return {1'b0, la, lb, pcw, adr, mw, irw, psh, pp, tos, rs, asa, asb, alu, dn};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic        zero;
    logic [19:0] exp;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] o, input logic z, input logic [19:0] e, input string t);
    vec_t v;
    v.op = o; v.zero = z; v.exp = e; v.tag = t;
    tbl.push_back(v);
  endtask

  task automatic check(input string t, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", t, act, exp);
    end
  endtask

  task automatic check_bit(input string t, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", t, act, exp);
    end
  endtask

  logic [19:0] e_f, e_d, e_pb, e_pa, e_wb, e_mr, e_pm, e_mw, e_j, e_jz1, e_jz0;
  logic [19:0] e_ex_add, e_ex_sub, e_ex_and, e_ex_not;

  initial begin
    //                la lb pcw adr mw irw psh pp tos rs     asa    asb    alu     dn
    e_f      = pk(0, 0, 1,  0,  0, 1,  0,  0, 0,  2'b10, 2'b00, 2'b10, 3'b000, 0);
    e_d      = 20'h0;
    e_pb     = pk(0, 1, 0,  0,  0, 0,  0,  1, 1,  2'b00, 2'b00, 2'b00, 3'b000, 0);
    e_pa     = pk(1, 0, 0,  0,  0, 0,  0,  1, 1,  2'b00, 2'b00, 2'b00, 3'b000, 0);
    e_ex_add = pk(0, 0, 0,  0,  0, 0,  0,  0, 0,  2'b00, 2'b10, 2'b00, 3'b000, 0);
    e_ex_sub = pk(0, 0, 0,  0,  0, 0,  0,  0, 0,  2'b00, 2'b10, 2'b00, 3'b001, 0);
    e_ex_and = pk(0, 0, 0,  0,  0, 0,  0,  0, 0,  2'b00, 2'b10, 2'b00, 3'b010, 0);
    e_ex_not = pk(0, 0, 0,  0,  0, 0,  0,  0, 0,  2'b00, 2'b10, 2'b00, 3'b011, 0);
    e_wb     = pk(0, 0, 0,  0,  0, 0,  1,  0, 0,  2'b00, 2'b00, 2'b00, 3'b000, 1);
    e_mr     = pk(0, 0, 0,  1,  0, 0,  0,  0, 0,  2'b11, 2'b00, 2'b00, 3'b000, 0);
    e_pm     = pk(0, 0, 0,  0,  0, 0,  1,  0, 0,  2'b01, 2'b00, 2'b00, 3'b000, 1);
    e_mw     = pk(0, 0, 0,  1,  1, 0,  0,  0, 0,  2'b11, 2'b00, 2'b00, 3'b000, 1);
    e_j      = pk(0, 0, 1,  0,  0, 0,  0,  0, 0,  2'b11, 2'b00, 2'b00, 3'b000, 1);
    e_jz1    = pk(0, 0, 1,  0,  0, 0,  0,  0, 0,  2'b11, 2'b10, 2'b00, 3'b100, 1);
    e_jz0    = pk(0, 0, 0,  0,  0, 0,  0,  0, 0,  2'b11, 2'b10, 2'b00, 3'b100, 1);

    // One row per clock cycle, instructions run back to back.
    add(3'b000, 0, e_f, "add_fetch");  add(3'b000, 0, e_d, "add_decode");
    add(3'b000, 0, e_pb, "add_popb");  add(3'b000, 0, e_pa, "add_popa");
    add(3'b000, 0, e_ex_add, "add_exec"); add(3'b000, 0, e_wb, "add_wb");
    add(3'b001, 0, e_f, "sub_fetch");  add(3'b001, 0, e_d, "sub_decode");
    add(3'b001, 0, e_pb, "sub_popb");  add(3'b001, 0, e_pa, "sub_popa");
    add(3'b001, 0, e_ex_sub, "sub_exec"); add(3'b001, 0, e_wb, "sub_wb");
    add(3'b011, 0, e_f, "not_fetch");  add(3'b011, 0, e_d, "not_decode");
    add(3'b011, 0, e_pa, "not_popa");  add(3'b011, 0, e_ex_not, "not_exec");
    add(3'b011, 0, e_wb, "not_wb");
    add(3'b100, 0, e_f, "push_fetch"); add(3'b100, 0, e_d, "push_decode");
    add(3'b100, 0, e_mr, "push_memrd"); add(3'b100, 0, e_pm, "push_pushm");
    add(3'b101, 0, e_f, "pop_fetch");  add(3'b101, 0, e_d, "pop_decode");
    add(3'b101, 0, e_pb, "pop_popb");  add(3'b101, 0, e_mw, "pop_memwr");
    add(3'b111, 1, e_f, "jz1_fetch");  add(3'b111, 1, e_d, "jz1_decode");
    add(3'b111, 1, e_pa, "jz1_popa");  add(3'b111, 1, e_jz1, "jz1_taken");
    add(3'b111, 0, e_f, "jz0_fetch");  add(3'b111, 0, e_d, "jz0_decode");
    add(3'b111, 0, e_pa, "jz0_popa");  add(3'b111, 0, e_jz0, "jz0_not_taken");
    add(3'b110, 0, e_f, "jmp_fetch");  add(3'b110, 0, e_d, "jmp_decode");
    add(3'b110, 0, e_j, "jmp_exec");
    add(3'b010, 1, e_f, "and_fetch");  add(3'b010, 1, e_d, "and_decode");
    add(3'b010, 1, e_pb, "and_popb");  add(3'b010, 1, e_pa, "and_popa");
    add(3'b010, 1, e_ex_and, "and_exec"); add(3'b010, 1, e_wb, "and_wb");

    rst  = 1'b0;
    step = 1'b0;
    op   = 3'b000;
    zero = 1'b0;
    #3;
    check("reset_outputs", obs, 20'h0);
    @(negedge clk);
    rst = 1'b1;

`ifdef CTRL_STEP_EN
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check($sformatf("wait_idle_%0d", i), obs, 20'h0);
    end
    op   = 3'b110;
    step = 1'b1;
    @(posedge clk); #2;
    step = 1'b0;
    check("step_fetch", obs, e_f);
    @(posedge clk); #2;
    check("step_decode", obs, e_d);
    @(posedge clk); #2;
    check("step_jmp", obs, e_j);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check($sformatf("step_back_to_wait_%0d", i), obs, 20'h0);
    end
`else
    for (int i = 0; i < tbl.size(); i++) begin
      op   = tbl[i].op;
      zero = tbl[i].zero;
      @(posedge clk); #2;
      check(tbl[i].tag, obs, tbl[i].exp);
      check_bit({tbl[i].tag, "_push_pop_excl"}, Push & Pop, 1'b0);
      check_bit({tbl[i].tag, "_memwr_adrsrc"}, MemWrite & ~AdrSrc, 1'b0);
    end

    // Reset asserted while in EXEC of an ADD.
    op   = 3'b000;
    zero = 1'b0;
    @(posedge clk); #2; check("mid_fetch", obs, e_f);
    @(posedge clk); #2; check("mid_decode", obs, e_d);
    @(posedge clk); #2; check("mid_popb", obs, e_pb);
    @(posedge clk); #2; check("mid_popa", obs, e_pa);
    @(posedge clk); #2; check("mid_exec", obs, e_ex_add);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_clear", obs, 20'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      check($sformatf("rst_held_%0d", i), obs, 20'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_release_before_edge", obs, 20'h0);
    @(posedge clk); #2; check("post_rst_fetch", obs, e_f);
    @(posedge clk); #2; check("post_rst_decode", obs, e_d);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
